// File: rtl/css_term_pipe.sv
// Three-stage float32 -> tanh(i/2) lookup pipeline with per-channel result registers.
// The index is floor(in * 2^SHIFT), saturated to the table range.
module css_term_pipe #(
  parameter int NCH   = 4,
  parameter int SHIFT = 10,
  parameter int DEPTH = 32,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [31:0]    in_data,
  input  logic [CHW-1:0] in_ch,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [31:0]    out_data,
  output logic [CHW-1:0] out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic [CHW-1:0] rd_ch,
  output logic [31:0]    rd_data
);

  localparam int IW = $clog2(DEPTH);

  // Elaboration-time float32 rounding of tanh(i/2) = (e^i - 1) / (e^i + 1).
  function automatic logic [31:0] tanh_half(input int unsigned i);
    real ex;
    real t;
    int  e;
    int  mi;
    logic [31:0] r;
    if (i == 0) begin
      r = '0;
    end else if (i >= 20) begin
      r = 32'h3F80_0000;
    end else begin
      ex = 1.0;
      for (int unsigned j = 0; j < i; j++) ex = ex * 2.718281828459045;
      t = (ex - 1.0) / (ex + 1.0);
      e = 150;
      for (int unsigned k = 0; k < 64; k++) begin
        if (t < 8388608.0) begin
          t = t * 2.0;
          e = e - 1;
        end
      end
      mi = $rtoi(t + 0.5);
      if (mi >= 16777216) begin
        mi = 8388608;
        e  = e + 1;
      end
      r = {1'b0, e[7:0], mi[22:0]};
    end
    return r;
  endfunction

  logic [31:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [31:0] VAL = tanh_half(g);
    assign rom[g] = VAL;
  end

  logic                 v1;
  logic                 v2;
  logic [31:0]          d1;
  logic [CHW-1:0]       c1;
  logic [CHW-1:0]       c2;
  logic [IW-1:0]        idx2;
  logic [IW-1:0]        idx_c;
  logic signed [10:0]   ex;
  logic [4:0]           sh;
  logic [23:0]          shifted;
  logic [31:0]          res [NCH];

  assign in_ready = !(out_valid && !out_ready);

  always_comb begin
    ex      = 11'(int'(d1[30:23]) - 127 + SHIFT);
    sh      = 5'(23 - int'(ex));
    shifted = {1'b1, d1[22:0]} >> sh;
    idx_c   = '0;
    if (d1[31] || (d1[30:23] == 8'h00) || (ex < 0)) begin
      idx_c = '0;
    end else if ((d1[30:23] == 8'hFF) || (int'(ex) >= IW)) begin
      idx_c = '1;
    end else if (shifted > 24'(DEPTH - 1)) begin
      idx_c = '1;
    end else begin
      idx_c = shifted[IW-1:0];
    end
  end

  // Single global enable: the whole pipe advances only when the output is not stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      d1        <= '0;
      c1        <= '0;
      v2        <= 1'b0;
      idx2      <= '0;
      c2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (in_ready) begin
      v1        <= in_valid;
      d1        <= in_data;
      c1        <= in_ch;
      v2        <= v1;
      idx2      <= idx_c;
      c2        <= c1;
      out_valid <= v2;
      out_data  <= rom[idx2];
      out_ch    <= c2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NCH; i++) res[i] <= '0;
    end else if (out_valid && out_ready) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (out_ch == CHW'(i)) res[i] <= out_data;
      end
    end
  end

  // Tags outside 0..NCH-1 match no register and read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_ch == CHW'(i)) rd_data = res[i];
    end
  end

endmodule
